// File: rtl/flame_gen.sv
`default_nettype none
// ============================================================================
//  Module   : flame_gen
//  Purpose  : Cross-shaped bomb explosion that grows cell by cell, holds at
//             full range, then clears. Produces a registered flame palette index.
//  Revision : 1.0
// ============================================================================
module flame_gen #(
  parameter int         CELL_LOG2   = 5,
  parameter int         GROW_FRAMES = 4,
  parameter int         HOLD_FRAMES = 30,
  parameter logic [7:0] TRANSPARENT = 8'd137,
  parameter logic [7:0] FLAME_BASE  = 8'd200
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       active,
  input  logic [9:0] x,
  input  logic [9:0] y,
  input  logic       frame_tick,
  input  logic       explode,
  input  logic [4:0] bomb_col,
  input  logic [3:0] bomb_row,
  input  logic [2:0] range,
  output logic [7:0] flame_color,
  output logic       busy,
  output logic       done
);

  localparam int CNT_MAX = (GROW_FRAMES > HOLD_FRAMES) ? GROW_FRAMES : HOLD_FRAMES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] GROW_LAST = CNT_W'(GROW_FRAMES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_FRAMES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_GROW = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [2:0]       radius_q, radius_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [4:0]       col_q, col_d;
  logic [3:0]       row_q, row_d;
  logic [2:0]       range_q, range_d;
  logic             done_q, done_d;
  logic [7:0]       color_q, color_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      radius_q <= 3'd0;
      cnt_q    <= '0;
      col_q    <= 5'd0;
      row_q    <= 4'd0;
      range_q  <= 3'd0;
      done_q   <= 1'b0;
      color_q  <= TRANSPARENT;
    end else begin
      state_q  <= state_d;
      radius_q <= radius_d;
      cnt_q    <= cnt_d;
      col_q    <= col_d;
      row_q    <= row_d;
      range_q  <= range_d;
      done_q   <= done_d;
      color_q  <= color_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    radius_d = radius_q;
    cnt_d    = cnt_q;
    col_d    = col_q;
    row_d    = row_q;
    range_d  = range_q;
    done_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        // A frame_tick coinciding with the accepted explode is deliberately not counted.
        if (explode) begin
          col_d    = bomb_col;
          row_d    = bomb_row;
          range_d  = range;
          radius_d = 3'd0;
          cnt_d    = '0;
          state_d  = (range != 3'd0) ? S_GROW : S_HOLD;
        end
      end
      S_GROW: begin
        if (frame_tick) begin
          if (cnt_q == GROW_LAST) begin
            cnt_d    = '0;
            radius_d = radius_q + 3'd1;
            if ((radius_q + 3'd1) == range_q) state_d = S_HOLD;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_HOLD: begin
        if (frame_tick) begin
          if (cnt_q == HOLD_LAST) begin
            state_d  = S_IDLE;
            radius_d = 3'd0;
            cnt_d    = '0;
            done_d   = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Cell distances are kept at 6 bits so the subtraction never wraps.
  logic [5:0] cx, cy, bc, br, dx, dy, rad6, dmax;
  logic       flame;

  always_comb begin
    cx    = 6'(x >> CELL_LOG2);
    cy    = 6'(y >> CELL_LOG2);
    bc    = {1'b0, col_q};
    br    = {2'b00, row_q};
    rad6  = {3'b000, radius_q};
    dx    = (cx >= bc) ? (cx - bc) : (bc - cx);
    dy    = (cy >= br) ? (cy - br) : (br - cy);
    dmax  = (dx > dy) ? dx : dy;
    flame = (state_q != S_IDLE) &&
            (((dy == 6'd0) && (dx <= rad6)) || ((dx == 6'd0) && (dy <= rad6)));

    color_d = TRANSPARENT;
    if (active && flame) begin
      if ((dx == 6'd0) && (dy == 6'd0))
        color_d = FLAME_BASE;
      else if ((dmax == rad6) && (radius_q != 3'd0))
        color_d = FLAME_BASE + 8'd2;
      else
        color_d = FLAME_BASE + 8'd1;
    end
  end

  assign flame_color = color_q;
  assign busy        = (state_q != S_IDLE);
  assign done        = done_q;

endmodule
`default_nettype wire

// File: doc/flame_gen.md
FLAME_GEN -- requirements
Module: flame_gen

Interface
REQ-001 Parameter CELL_LOG2, default 5: cell edge is 2^CELL_LOG2 pixels (32).
REQ-002 Parameter GROW_FRAMES, default 4: frames per one-cell radius increment.
REQ-003 Parameter HOLD_FRAMES, default 30: frames the full-range flame persists.
REQ-004 Parameter TRANSPARENT, default 8'd137: palette index meaning "no flame pixel".
REQ-005 Parameter FLAME_BASE, default 8'd200: palette index of flame centre; FLAME_BASE+1 arm, FLAME_BASE+2 tip.
REQ-006 clk  in  1  single clock, all state on rising edge.
REQ-007 reset  in  1  asynchronous, active-high reset.
REQ-008 active  in  1  pixel is in the visible area.
REQ-009 x  in  10  current pixel column, 0..639.
REQ-010 y  in  10  current pixel row, 0..479.
REQ-011 frame_tick  in  1  one-cycle pulse once per frame (end of visible area).
REQ-012 explode  in  1  one-cycle request to start an explosion.
REQ-013 bomb_col  in  5  bomb cell column, sampled on accepted explode.
REQ-014 bomb_row  in  4  bomb cell row, sampled on accepted explode.
REQ-015 range  in  3  maximum flame radius in cells, sampled on accepted explode.
REQ-016 flame_color  out  8  palette index to the mixer's flame layer.
REQ-017 busy  out  1  high while an explosion is in progress (state != IDLE).
REQ-018 done  out  1  one-cycle pulse when an explosion ends.

Function
REQ-019 FSM states IDLE, GROW, HOLD.
REQ-020 IDLE: explode=1 accepted; latches bomb_col, bomb_row, range; radius<=0; frame counter<=0; next state GROW if range>0, else HOLD.
REQ-021 explode while busy=1 is ignored; latched values stay unchanged.
REQ-022 GROW: each frame_tick increments frame counter; at the GROW_FRAMES-th tick, counter<=0 and radius<=radius+1; if the new radius equals latched range, next state HOLD.
REQ-023 HOLD: each frame_tick increments frame counter; at the HOLD_FRAMES-th tick, next state IDLE, radius<=0, done pulses for exactly that one cycle.
REQ-024 frame_tick in the same cycle as an accepted explode is not counted.
REQ-025 Pixel cell: cx = x >> CELL_LOG2, cy = y >> CELL_LOG2; dx = |cx - bomb_col|, dy = |cy - bomb_row|, unsigned, no wrap (computed at 6 bits, compared against zero-extended radius).
REQ-026 Pixel is flame if busy and ((dy==0 and dx<=radius) or (dx==0 and dy<=radius)).
REQ-027 Colour: dx==0 and dy==0 -> FLAME_BASE; flame with max(dx,dy)==radius and radius>0 -> FLAME_BASE+2; other flame -> FLAME_BASE+1; non-flame -> TRANSPARENT.
REQ-028 flame_color is registered: value for (x,y,active) presented at cycle n appears at cycle n+1.
REQ-029 active=0 at cycle n -> flame_color=TRANSPARENT at cycle n+1.
REQ-030 Flame cells outside the 20x15 board are never addressed; no clipping logic beyond REQ-025.
REQ-031 radius changes only on frame_tick, so colour geometry is stable within a frame.

Reset
REQ-032 reset=1 immediately forces state IDLE, radius 0, frame counter 0, latched bomb/range 0, flame_color=TRANSPARENT, busy=0, done=0.
REQ-033 reset mid-explosion abandons it without a done pulse; first explode after reset release is accepted normally.

Verification
REQ-034 explode with bomb_col=5, bomb_row=3, range=2; 4 frame_ticks -> radius 1; 8 ticks -> HOLD; pixel (5*32+1, 3*32+1) -> 200, (7*32, 3*32) -> 202, (6*32, 3*32) -> 201, (6*32, 4*32) -> 137.
REQ-035 range=0 explode -> HOLD directly, only bomb cell = 200; after 30 ticks done pulses one cycle, busy falls, all pixels 137.
REQ-036 explode during GROW with different bomb_col -> ignored, geometry and timing of first explosion unchanged.
REQ-037 explode and frame_tick same cycle -> explosion ends after exactly GROW_FRAMES*range+HOLD_FRAMES further ticks.
REQ-038 reset asserted in HOLD -> flame_color 137 and busy 0 without clock edge; no done pulse.
REQ-039 active=0 with x,y in flame cell -> next cycle flame_color 137; 1-cycle latency checked on every pixel.
